// File: rtl/if_stage_fetch_unit.sv
// rtl/if_stage_fetch_unit.sv - IF stage: PC, imem wait-state handshake, IF/ID register; optional counters under IF_PERF_CNT_EN
module if_stage_fetch_unit #(
    parameter int                 PC_W      = 16,
    parameter int                 INSTR_W   = 16,
    parameter logic [PC_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_write,
    input  logic               id_write,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc_plus1,
    output logic               if_id_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        miss_cnt,
    output logic [15:0]        flush_cnt
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        MISS = 2'd2
    } state_t;

    state_t          state;
    logic            in_boot;
    logic            do_flush;
    logic            do_stall;
    logic            do_miss;
    logic [PC_W-1:0] pc_plus1;

    // Word-addressed sequential PC; wraps naturally at 2^PC_W.
    assign pc_plus1  = pc + PC_W'(1);
    assign imem_addr = pc;

    // Priority decode: flush > stall > miss > fetch. The illegal
    // pc_write=1/id_write=0 combination falls into the stall case.
    assign in_boot  = (state == BOOT);
    assign do_flush = !in_boot && branch_taken;
    assign do_stall = !in_boot && !branch_taken && !(pc_write && id_write);
    assign do_miss  = !in_boot && !branch_taken && pc_write && id_write && !imem_ready;

    // PC, IF/ID register and fetch FSM, all registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= BOOT;
            pc             <= RESET_PC;
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus1 <= '0;
            if_id_valid    <= 1'b0;
        end else if (in_boot) begin
            state <= RUN;
        end else if (do_flush) begin
            pc          <= branch_target;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            state       <= RUN;
        end else if (do_stall) begin
            if (id_write) begin
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
            end
        end else if (do_miss) begin
            state       <= MISS;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else begin
            pc             <= pc_plus1;
            if_id_instr    <= imem_rdata;
            if_id_pc_plus1 <= pc_plus1;
            if_id_valid    <= 1'b1;
            state          <= RUN;
        end
    end

`ifdef IF_PERF_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating event counters, one per priority rule that can stop the fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            miss_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            if (do_stall) stall_cnt <= sat_inc(stall_cnt);
            if (do_miss)  miss_cnt  <= sat_inc(miss_cnt);
            if (do_flush) flush_cnt <= sat_inc(flush_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_if_stage_fetch_unit.sv
// tb/tb_if_stage_fetch_unit.sv - table-driven bench for if_stage_fetch_unit
module tb_if_stage_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_write;
    logic        id_write;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic [15:0] pc;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus1;
    logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] miss_cnt;
    logic [15:0] flush_cnt;
`endif

    int n_applied = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    // Memory model: word at address A holds A + 0x1000.
    assign imem_rdata = imem_addr + 16'h1000;

    if_stage_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_write       (pc_write),
        .id_write       (id_write),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_ready     (imem_ready),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .miss_cnt       (miss_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    typedef struct {
        logic        pw;
        logic        iw;
        logic        br;
        logic [15:0] tgt;
        logic        rdy;
        logic [15:0] exp_pc;
        logic [15:0] exp_instr;
        logic [15:0] exp_pp1;
        logic        exp_valid;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] e_pc, input logic [15:0] e_instr,
                                 input logic [15:0] e_pp1, input logic e_valid);
        check({tag, ".pc"}, 32'(pc), 32'(e_pc));
        check({tag, ".imem_addr"}, 32'(imem_addr), 32'(e_pc));
        check({tag, ".valid"}, 32'(if_id_valid), 32'(e_valid));
        check({tag, ".instr"}, 32'(if_id_instr), 32'(e_instr));
        if (e_valid) check({tag, ".pc_plus1"}, 32'(if_id_pc_plus1), 32'(e_pp1));
    endtask

    function automatic vec_t mk(input logic pw, input logic iw, input logic br, input logic [15:0] tgt,
                                input logic rdy, input logic [15:0] e_pc, input logic [15:0] e_instr,
                                input logic [15:0] e_pp1, input logic e_valid);
        vec_t v;
        v.pw = pw; v.iw = iw; v.br = br; v.tgt = tgt; v.rdy = rdy;
        v.exp_pc = e_pc; v.exp_instr = e_instr; v.exp_pp1 = e_pp1; v.exp_valid = e_valid;
        return v;
    endfunction

    // The hazard unit must never raise pc_write without id_write.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && pc_write === 1'b1 && id_write === 1'b0) begin
            n_fail++;
            $display("FAIL illegal_hazard: pc_write=1 id_write=0 at %0t", $time);
        end
    end

    initial begin
        //              pw    iw    br    tgt      rdy   pc       instr    pp1      valid
        vecs[0]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0); // BOOT
        vecs[1]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h1000, 16'h0001, 1'b1);
        vecs[2]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h1001, 16'h0002, 1'b1);
        vecs[3]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 16'h1002, 16'h0003, 1'b1);
        vecs[4]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 16'h1003, 16'h0004, 1'b1);
        vecs[5]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'h1004, 16'h0005, 1'b1);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'h1004, 16'h0005, 1'b1); // full stall
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'h1004, 16'h0005, 1'b1);
        vecs[8]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0006, 16'h1005, 16'h0006, 1'b1);
        vecs[9]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0007, 16'h1006, 16'h0007, 1'b1);
        vecs[10] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008, 16'h1007, 16'h0008, 1'b1);
        vecs[11] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0008, 16'h0000, 16'h0000, 1'b0); // miss x3
        vecs[12] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0008, 16'h0000, 16'h0000, 1'b0);
        vecs[13] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0008, 16'h0000, 16'h0000, 1'b0);
        vecs[14] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0009, 16'h1008, 16'h0009, 1'b1);
        vecs[15] = mk(1'b0, 1'b0, 1'b1, 16'h0040, 1'b1, 16'h0040, 16'h0000, 16'h0000, 1'b0); // flush over stall
        vecs[16] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0041, 16'h1040, 16'h0041, 1'b1);
        vecs[17] = mk(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
        vecs[18] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0FFF, 16'h0000, 1'b1); // wrap
        vecs[19] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h1000, 16'h0001, 1'b1);
        vecs[20] = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b0); // bubble
        vecs[21] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h1001, 16'h0002, 1'b1);
        vecs[22] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0002, 16'h0000, 16'h0000, 1'b0);
        vecs[23] = mk(1'b1, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0); // flush in MISS
        vecs[24] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0011, 16'h1010, 16'h0011, 1'b1);

        rst_n = 1'b0;
        pc_write = 1'b1;
        id_write = 1'b1;
        branch_taken = 1'b0;
        branch_target = 16'h0000;
        imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        check("reset.pc_plus1", 32'(if_id_pc_plus1), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            pc_write      = vecs[i].pw;
            id_write      = vecs[i].iw;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            imem_ready    = vecs[i].rdy;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_instr,
                          vecs[i].exp_pp1, vecs[i].exp_valid);
            @(negedge clk);
        end

        // Asynchronous reset while a miss is outstanding.
        pc_write = 1'b1;
        id_write = 1'b1;
        branch_taken = 1'b0;
        imem_ready = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("miss_pre_rst", 16'h0011, 16'h0000, 16'h0000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        check("async_rst.pc_plus1", 32'(if_id_pc_plus1), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_ready = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("reboot", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        check_outputs("refetch", 16'h0001, 16'h1000, 16'h0001, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
        $finish;
    end

endmodule
